// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe_reg delay-line pipeline.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH_DEF  = 16;
  localparam int DFF_PIPE_STAGES_DEF = 4;

  // Occupancy must represent 0..stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module dff_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             SClr,
  input  logic             En,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (SClr) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (En) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe_reg.sv
// WIDTH x STAGES register pipeline with per-stage valid, stall, sync clear and occupancy.
// Build option DFF_PIPE_ZERO_INVALID_EN: stage 0 loads RESET_VAL when the input is invalid.
module dff_pipe_reg
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter int               STAGES    = DFF_PIPE_STAGES_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                            Clock,
  input  logic                            Resetn,
  input  logic                            En,
  input  logic                            SClr,
  input  logic [WIDTH-1:0]                D,
  input  logic                            Din_valid,
  output logic [WIDTH-1:0]                Q,
  output logic                            Q_valid,
  output logic [STAGES*WIDTH-1:0]         Taps,
  output logic [occ_width(STAGES)-1:0]    Occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic             stage_v [STAGES];
  logic [WIDTH-1:0] d0;

`ifdef DFF_PIPE_ZERO_INVALID_EN
  assign d0 = Din_valid ? D : RESET_VAL;
`else
  assign d0 = D;
`endif

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("dff_pipe_reg: STAGES must be at least 1");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
          .Clock   (Clock),
          .Resetn  (Resetn),
          .SClr    (SClr),
          .En      (En),
          .d       (d0),
          .d_valid (Din_valid),
          .q       (stage_d[k]),
          .q_valid (stage_v[k])
        );
      end else begin : g_body
        dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
          .Clock   (Clock),
          .Resetn  (Resetn),
          .SClr    (SClr),
          .En      (En),
          .d       (stage_d[k-1]),
          .d_valid (stage_v[k-1]),
          .q       (stage_d[k]),
          .q_valid (stage_v[k])
        );
      end
      assign Taps[k*WIDTH +: WIDTH] = stage_d[k];
    end
  endgenerate

  assign Q       = stage_d[STAGES-1];
  assign Q_valid = stage_v[STAGES-1];

  // Tracks entry vs. exit of valid words, so it equals the valid popcount without an adder tree.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Occupancy <= '0;
    end else if (SClr) begin
      Occupancy <= '0;
    end else if (En) begin
      case ({Din_valid, stage_v[STAGES-1]})
        2'b10:   Occupancy <= Occupancy + OCC_W'(1);
        2'b01:   Occupancy <= Occupancy - OCC_W'(1);
        default: Occupancy <= Occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Scoreboard bench for dff_pipe_reg: history-based reference model plus an output monitor.
module tb_dff_pipe_reg;

  localparam int               WIDTH   = 16;
  localparam int               STAGES  = 4;
  localparam int               OCC_W   = $clog2(STAGES + 1);
  localparam logic [WIDTH-1:0] RST_VAL = '0;

  logic                     Clock     = 1'b0;
  logic                     Resetn    = 1'b0;
  logic                     En        = 1'b0;
  logic                     SClr      = 1'b0;
  logic [WIDTH-1:0]         D         = '0;
  logic                     Din_valid = 1'b0;
  logic [WIDTH-1:0]         Q;
  logic                     Q_valid;
  logic [STAGES*WIDTH-1:0]  Taps;
  logic [OCC_W-1:0]         Occupancy;

  dff_pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VAL(RST_VAL)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .En        (En),
    .SClr      (SClr),
    .D         (D),
    .Din_valid (Din_valid),
    .Q         (Q),
    .Q_valid   (Q_valid),
    .Taps      (Taps),
    .Occupancy (Occupancy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             v;
  } ent_t;

  // hist holds the last STAGES accepted words, oldest (= stage STAGES-1) at the front.
  ent_t             hist  [$];
  logic [WIDTH-1:0] exp_q [$];
  ent_t             new_e;
  bit               shifted;
  bit               mon_on;
  int               checks;
  int               errors;

  function automatic void model_clear();
    ent_t e;
    e.data = RST_VAL;
    e.v    = 1'b0;
    hist.delete();
    for (int i = 0; i < STAGES; i++) hist.push_back(e);
    exp_q.delete();
  endfunction

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn || SClr) begin
      model_clear();
      shifted = 1'b0;
    end else if (En) begin
`ifdef DFF_PIPE_ZERO_INVALID_EN
      new_e.data = Din_valid ? D : RST_VAL;
`else
      new_e.data = D;
`endif
      new_e.v = Din_valid;
      hist.push_back(new_e);
      void'(hist.pop_front());
      if (Din_valid) exp_q.push_back(D);
      shifted = 1'b1;
    end else begin
      shifted = 1'b0;
    end
  end

  task automatic check_state(input string tag);
    logic [STAGES*WIDTH-1:0] et;
    logic [WIDTH-1:0]        ew;
    int                      occ;
    occ = 0;
    for (int k = 0; k < STAGES; k++) begin
      et[k*WIDTH +: WIDTH] = hist[STAGES-1-k].data;
      occ += int'(hist[STAGES-1-k].v);
    end
    checks++;
    if (Taps !== et) begin
      errors++;
      $display("FAIL %s taps: got %h expected %h", tag, Taps, et);
    end
    checks++;
    if (Q_valid !== hist[0].v) begin
      errors++;
      $display("FAIL %s q_valid: got %b expected %b", tag, Q_valid, hist[0].v);
    end
    checks++;
    if (Occupancy !== OCC_W'(occ)) begin
      errors++;
      $display("FAIL %s occupancy: got %0d expected %0d", tag, Occupancy, occ);
    end
    if (shifted && Q_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s sb_q: got %h valid, expected no valid word", tag, Q);
      end else begin
        ew = exp_q.pop_front();
        if (Q !== ew) begin
          errors++;
          $display("FAIL %s sb_q: got %h expected %h", tag, Q, ew);
        end
      end
    end
  endtask

  always @(negedge Clock) begin
    if (mon_on) check_state("cycle");
  end

  task automatic drive(input logic en, input logic sclr, input logic [WIDTH-1:0] d,
                       input logic dv);
    @(negedge Clock);
    En        = en;
    SClr      = sclr;
    D         = d;
    Din_valid = dv;
  endtask

  task automatic rnd_word(output logic [WIDTH-1:0] w);
    w = WIDTH'($urandom);
  endtask

  task automatic async_rst();
    @(negedge Clock);
    En        = 1'b1;
    Din_valid = 1'b1;
    D         = WIDTH'($urandom);
    #2 Resetn = 1'b0;
    #1 check_state("async_rst");
    #1 Resetn = 1'b1;
  endtask

  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] exp_tap0;

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    shifted = 1'b0;
    mon_on  = 1'b1;

    // reset held with active inputs
    D = 16'hFFFF; Din_valid = 1'b1; En = 1'b1;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;

    // basic fill and flush
    drive(1, 0, 16'hAAAA, 1);
    drive(1, 0, 16'h5555, 1);
    drive(1, 0, 16'hF0F0, 1);
    drive(1, 0, 16'h0F0F, 1);
    for (int i = 0; i < 5; i++) begin rnd_word(w); drive(1, 0, w, 0); end

    // stall
    drive(1, 0, 16'h1234, 1);
    drive(1, 0, 16'h5678, 1);
    for (int i = 0; i < 3; i++) begin rnd_word(w); drive(0, 0, w, 1'($urandom)); end
    for (int i = 0; i < 4; i++) begin rnd_word(w); drive(1, 0, w, 0); end

    // bubbles
    drive(0, 1, 16'h0000, 0);
    drive(1, 0, 16'hAAAA, 1);
    rnd_word(w); drive(1, 0, w, 0);
    drive(1, 0, 16'hBBBB, 1);
    rnd_word(w); drive(1, 0, w, 0);
    for (int i = 0; i < 5; i++) begin rnd_word(w); drive(1, 0, w, 0); end

    // clear beats enable
    for (int i = 0; i < 4; i++) begin rnd_word(w); drive(1, 0, w, 1); end
    drive(1, 1, 16'hCAFE, 1);
    for (int i = 0; i < 5; i++) begin rnd_word(w); drive(1, 0, w, 0); end

    // async reset with pipe half full
    drive(1, 0, 16'h1111, 1);
    drive(1, 0, 16'h2222, 1);
    async_rst();
    for (int i = 0; i < 5; i++) begin rnd_word(w); drive(1, 0, w, 1); end

    // invalid word into stage 0
    drive(1, 0, 16'hDEAD, 0);
    drive(0, 0, 16'h0000, 0);
`ifdef DFF_PIPE_ZERO_INVALID_EN
    exp_tap0 = RST_VAL;
`else
    exp_tap0 = 16'hDEAD;
`endif
    checks++;
    if (Taps[WIDTH-1:0] !== exp_tap0) begin
      errors++;
      $display("FAIL tap0_invalid: got %h expected %h", Taps[WIDTH-1:0], exp_tap0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 99) begin
        async_rst();
      end else begin
        rnd_word(w);
        drive(1'($urandom_range(0, 99) < 75), 1'(r < 3), w, 1'($urandom));
      end
    end

    for (int i = 0; i < STAGES + 2; i++) begin rnd_word(w); drive(1, 0, w, 0); end
    @(negedge Clock);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
